x_ramd_wide_adv: RTL and testbench

X_RAMD_WIDE_ADV -- requirements
Module: x_ramd_wide_adv

---
 rtl/x_ramd_wide_adv.sv | 100 ++++++++++
 tb/tb_x_ramd_wide_adv.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_ramd_wide_adv.sv
// Wide distributed RAM: one write port, one asynchronous read port, and a synchronous restore to INIT.
// Optional X_RAMD_OREG_EN registers the read port, which adds one cycle of read latency.
module x_ramd_wide_adv #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned ADDR_W = 6,
    parameter logic [WIDTH*(2**ADDR_W)-1:0] INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  I,
    input  logic [ADDR_W-1:0] WADR,
    input  logic [ADDR_W-1:0] RADR,
    input  logic              WE,
    input  logic              WE1,
    input  logic              WE2,
    output logic [WIDTH-1:0]  O,
    output logic              CLR_BUSY
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t                   state = IDLE;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        cnt = '0;
    logic [ADDR_W-1:0]        cnt_nxt;
    logic [ADDR_W-1:0]        cnt_inc;
    logic [WIDTH*DEPTH-1:0]   mem = INIT;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WIDTH-1:0]         wr_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RESTORE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The RST edge restores word 0. Each later edge restores word cnt+1,
    // so the edge that writes the last word also returns the FSM to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + ADDR_W'(1);
        wr_en     = 1'b0;
        wr_addr   = WADR;
        wr_data   = I;
        if (RST) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = INIT[WIDTH-1:0];
        end else begin
            case (state)
                IDLE: begin
                    wr_en = WE & WE1 & WE2;
                end
                RESTORE: begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_inc;
                    wr_data = INIT[cnt_inc*WIDTH +: WIDTH];
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == '1) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr*WIDTH +: WIDTH] <= wr_data;
        end
    end

    assign CLR_BUSY = (state == RESTORE);

`ifdef X_RAMD_OREG_EN
    logic [WIDTH-1:0] o_q = '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_q <= '0;
        end else begin
            o_q <= mem[RADR*WIDTH +: WIDTH];
        end
    end

    assign O = o_q;
`else
    assign O = mem[RADR*WIDTH +: WIDTH];
`endif

endmodule

// File: tb/tb_x_ramd_wide_adv.sv
// Scoreboard bench for x_ramd_wide_adv: a 16x8 instance and a 2x1 instance.
// Expectations go into a queue, and a monitor process pops each one and compares it against the DUT outputs.
module tb_x_ramd_wide_adv;

    localparam logic [127:0] INIT_BIG = 128'hFFEEDDCCBBAA99887766554433221100;
`ifdef X_RAMD_OREG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, we, we1, we2, busy;
    logic [7:0] i, o;
    logic [3:0] wadr, radr;
    logic       s_rst, s_we, s_busy;
    logic [0:0] s_i, s_o, s_wadr, s_radr;

    always #10 clk = ~clk;

    x_ramd_wide_adv #(.WIDTH(8), .ADDR_W(4), .INIT(INIT_BIG)) dut (
        .CLK(clk), .RST(rst), .I(i), .WADR(wadr), .RADR(radr),
        .WE(we), .WE1(we1), .WE2(we2), .O(o), .CLR_BUSY(busy)
    );

    x_ramd_wide_adv #(.WIDTH(1), .ADDR_W(1), .INIT(2'b10)) dut_s (
        .CLK(clk), .RST(s_rst), .I(s_i), .WADR(s_wadr), .RADR(s_radr),
        .WE(s_we), .WE1(s_we), .WE2(1'b1), .O(s_o), .CLR_BUSY(s_busy)
    );

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   tests = 0;
    int   fails = 0;

    // sel: 0 = big O, 1 = big CLR_BUSY, 2 = small O, 3 = small CLR_BUSY
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       act = o;
                    1:       act = {7'b0, busy};
                    2:       act = {7'b0, s_o};
                    default: act = {7'b0, s_busy};
                endcase
                tests++;
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input logic [7:0] exp, input string name);
        exp_t e;
        #1;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
        ->chk_ev;
        #1;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [7:0] exp, input string name);
        radr = addr;
        if (OREG) tick();
        chk(0, exp, name);
    endtask

    task automatic srd(input logic [0:0] addr, input logic [7:0] exp, input string name);
        s_radr = addr;
        if (OREG) tick();
        chk(2, exp, name);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data, input logic e2);
        wadr = addr;
        i    = data;
        we   = 1'b1;
        we1  = 1'b1;
        we2  = e2;
        tick();
        we   = 1'b0;
        we1  = 1'b0;
        we2  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; i = '0; wadr = '0; radr = '0; we = 1'b0; we1 = 1'b0; we2 = 1'b0;
        s_rst = 1'b0; s_i = '0; s_wadr = '0; s_radr = '0; s_we = 1'b0;
        #1;
        chk(1, 8'd0, "init_busy");
        for (int n = 0; n < 16; n++) rd(4'(n), 8'(n * 17), $sformatf("init_rd%0d", n));

        wr(4'd5, 8'hA5, 1'b1);
        rd(4'd5, 8'hA5, "wr5");
        wr(4'd5, 8'h5A, 1'b0);
        rd(4'd5, 8'hA5, "we2_low");
        wadr = 4'd5; i = 8'h3C; we1 = 1'b1; we2 = 1'b1;
        tick();
        we1 = 1'b0; we2 = 1'b0;
        rd(4'd5, 8'hA5, "we_low");

        for (int n = 0; n < 16; n++) wr(4'(n), 8'hFF, 1'b1);
        rd(4'd9, 8'hFF, "fill");

        // restore from RST held for one edge; a write on that edge is dropped
        radr = 4'd0; rst = 1'b1;
        wadr = 4'd3; i = 8'h00; we = 1'b1; we1 = 1'b1; we2 = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; we1 = 1'b0; we2 = 1'b0;
        chk(1, 8'd1, "rst_busy");
        if (!OREG) begin
            chk(0, 8'h00, "rst_w0");
            radr = 4'd1; chk(0, 8'hFF, "rst_w1_old");
            radr = 4'd3; chk(0, 8'hFF, "rst_edge_wr_ignored");
        end
        for (int k = 1; k < 16; k++) begin
            tick();
            chk(1, (k < 15) ? 8'd1 : 8'd0, $sformatf("restore_busy%0d", k));
            if (!OREG) begin
                radr = 4'(k);
                chk(0, 8'(k * 17), $sformatf("restore_w%0d", k));
                if (k < 15) begin
                    radr = 4'(k + 1);
                    chk(0, 8'hFF, $sformatf("restore_hi%0d", k + 1));
                end
            end
        end
        for (int n = 0; n < 16; n++) rd(4'(n), 8'(n * 17), $sformatf("post_restore%0d", n));

        // mid-restore write is ignored, then RST at CNT=9 restarts
        for (int n = 0; n < 16; n++) wr(4'(n), 8'hFF, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        wadr = 4'd12; i = 8'h00; we = 1'b1; we1 = 1'b1; we2 = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; we1 = 1'b0; we2 = 1'b0;
        chk(1, 8'd1, "restart_busy");
        if (!OREG) begin
            radr = 4'd12; chk(0, 8'hFF, "restore_wr_ignored");
            radr = 4'd9;  chk(0, 8'h99, "pre_restart_w9");
        end
        for (int k = 1; k < 16; k++) begin
            tick();
            chk(1, (k < 15) ? 8'd1 : 8'd0, $sformatf("restart_busy%0d", k));
        end
        rd(4'd12, 8'hCC, "restart_w12");
        rd(4'd14, 8'hEE, "restart_w14");

`ifdef X_RAMD_OREG_EN
        radr = 4'd6;
        tick();
        radr = 4'd2;
        chk(0, 8'h66, "oreg_hold");
        tick();
        chk(0, 8'h22, "oreg_lat");
        wadr = 4'd2; i = 8'h77; we = 1'b1; we1 = 1'b1; we2 = 1'b1;
        tick();
        we = 1'b0; we1 = 1'b0; we2 = 1'b0;
        chk(0, 8'h22, "oreg_old");
        tick();
        chk(0, 8'h77, "oreg_new");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(0, 8'h00, "oreg_rst");
        repeat (15) tick();
        chk(1, 8'd0, "oreg_restore_done");
        rd(4'd2, 8'h22, "oreg_restored_w2");
`endif

        // 2-word, 1-bit instance: invert contents, then restore in one extra edge
        s_wadr = 1'b0; s_i = 1'b1; s_we = 1'b1;
        tick();
        s_wadr = 1'b1; s_i = 1'b0;
        tick();
        s_we = 1'b0;
        srd(1'b0, 8'd1, "s_pre0");
        srd(1'b1, 8'd0, "s_pre1");
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk(3, 8'd1, "s_busy");
        tick();
        chk(3, 8'd0, "s_done");
        srd(1'b0, 8'd0, "s_w0");
        srd(1'b1, 8'd1, "s_w1");

        #5;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
